// File: rtl/sys_bus_arb_pkg.sv
// Shared types and constants for the two-primary system bus arbiter.
//   arb_state_t     : arbiter FSM state (IDLE, BUSY)
//   grant_id_t      : index of the primary that owns the bus
//   DEFAULT_TIMEOUT : default secondary-ack timeout in cycles
package sys_bus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [0:0] grant_id_t;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Single-transaction request/acknowledge bus between one primary and one
// secondary.
//   req   : transaction request, held until ack
//   addr  : address
//   we    : write enable
//   be    : byte enables
//   wdata : write data
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack
// The master modport is the side that issues requests; the slave modport is
// the side that completes them.
interface sys_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/sys_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req   : request vector, bit i = primary i
//   last  : primary that completed most recently
//   mask  : requests to ignore this cycle
//   valid : at least one unmasked request
//   id    : winning primary (a lone request wins; a tie goes to the primary
//           that is not last)
module rr_pick2
    import sys_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_id_t  last,
    input  logic [1:0] mask,
    output logic       valid,
    output grant_id_t  id
);

    logic [1:0] eff;

    always_comb begin
        eff   = req & ~mask;
        valid = |eff;
        id    = 1'b0;
        case (eff)
            2'b10:   id = 1'b1;
            2'b11:   id = ~last;
            default: id = 1'b0;
        endcase
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one memory secondary between the CPU core
// (primary 0) and the loader / debug DMA (primary 1). One transaction at a
// time; the owner's request is forwarded to the secondary and the ack/rdata
// are routed back to the owner only.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   m0, m1   : primary-facing buses (slave modport)
//   s        : secondary-facing bus (master modport)
//   grant_id : current owner, valid while s.req is high
//   err      : one-cycle pulse when a transaction is aborted by timeout
// Build option SYS_BUS_ARB_TIMEOUT_EN adds the TIMEOUT parameter and an
// abort after TIMEOUT BUSY cycles without s.ack; without it err is tied 0
// and BUSY waits for s.ack indefinitely.
//
// state | meaning
// IDLE  | no owner, secondary idle, waiting for any request
// BUSY  | grant_id owns the bus, request forwarded to the secondary
module sys_bus_arbiter
    import sys_bus_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef SYS_BUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    sys_bus_arbiter_if.slave         m0,
    sys_bus_arbiter_if.slave         m1,
    sys_bus_arbiter_if.master        s,
    output grant_id_t                grant_id,
    output logic                     err
);

    arb_state_t state_q, state_d;
    grant_id_t  gid_q, gid_d;
    grant_id_t  last_q, last_d;

    logic       busy;
    logic       sel1;
    logic       tmo;
    logic       done;
    logic [1:0] pick_mask;
    logic       pick_valid;
    grant_id_t  pick_id;

    logic [ADDR_W-1:0]   fwd_addr;
    logic                fwd_we;
    logic [DATA_W/8-1:0] fwd_be;
    logic [DATA_W-1:0]   fwd_wdata;

    assign busy = (state_q == BUSY);
    assign sel1 = (gid_q == 1'b1);
    assign done = busy && (s.ack || tmo);

    // On completion the finishing primary is masked, so the picker can only
    // hand the bus straight to the other primary (zero-bubble handover).
    assign pick_mask = done ? {sel1, ~sel1} : 2'b00;

    rr_pick2 u_pick (
        .req   ({m1.req, m0.req}),
        .last  (last_q),
        .mask  (pick_mask),
        .valid (pick_valid),
        .id    (pick_id)
    );

`ifdef SYS_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Cleared while idle and on every completion, so each granted
    // transaction starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || !busy || done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A real ack in the timeout cycle wins: no abort, real read data.
    assign tmo = busy && !s.ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign err = tmo;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    gid_d   = pick_id;
                end
            end
            BUSY: begin
                if (done) begin
                    last_d = gid_q;
                    if (pick_valid) begin
                        gid_d = pick_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fwd_addr  = '0;
        fwd_we    = 1'b0;
        fwd_be    = '0;
        fwd_wdata = '0;
        if (busy) begin
            if (sel1) begin
                fwd_addr  = m1.addr;
                fwd_we    = m1.we;
                fwd_be    = m1.be;
                fwd_wdata = m1.wdata;
            end else begin
                fwd_addr  = m0.addr;
                fwd_we    = m0.we;
                fwd_be    = m0.be;
                fwd_wdata = m0.wdata;
            end
        end
    end

    assign s.req   = busy;
    assign s.addr  = fwd_addr;
    assign s.we    = fwd_we;
    assign s.be    = fwd_be;
    assign s.wdata = fwd_wdata;

    assign m0.ack   = done && !sel1;
    assign m1.ack   = done && sel1;
    // Only a real secondary ack carries data; a timeout abort returns zero.
    assign m0.rdata = (m0.ack && s.ack) ? s.rdata : '0;
    assign m1.rdata = (m1.ack && s.ack) ? s.rdata : '0;

    assign grant_id = gid_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] grant_id;
    logic       err;

    always #5 clk = ~clk;

    sys_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    sys_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    sys_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    sys_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant_id (grant_id),
        .err      (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          r0;
        bit          r1;
        bit          sack;
        logic [31:0] rd;
        bit          e_sreq;
        bit          e_gid;
        bit          e_a0;
        bit          e_a1;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int p, input bit rq, input logic [31:0] a, input bit w,
                         input logic [3:0] b, input logic [31:0] d);
        if (p == 0) begin
            m0_if.req = rq; m0_if.addr = a; m0_if.we = w; m0_if.be = b; m0_if.wdata = d;
        end else begin
            m1_if.req = rq; m1_if.addr = a; m1_if.we = w; m1_if.be = b; m1_if.wdata = d;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_if.ack   = 1'b0;
        s_if.rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        int owner, last, o;
        bit rq[2], acked[2], ea[2], busy_m, we_r[2];
        logic [31:0] ad[2], wd[2], srd;
        logic [3:0]  be_r[2];
        bit sack;

        // cycle-by-cycle vectors starting right after reset (m0 @0x100, m1 @0x2000)
        tbl[0]  = '{0, 0, 1, 32'h0000_0011, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 32'h0000_0022, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 32'h0000_0033, 1, 0, 1, 0};
        tbl[3]  = '{1, 1, 1, 32'h0000_0044, 1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 32'h0000_0055, 1, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 32'h0000_0066, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 1, 32'h0000_0077, 1, 1, 0, 1};
        tbl[7]  = '{0, 1, 0, 32'h0000_0088, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 1, 32'h0000_0099, 1, 1, 0, 1};
        tbl[9]  = '{1, 0, 1, 32'h0000_00AA, 1, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 32'h0000_00BB, 0, 0, 0, 0};

        // reset state
        apply_reset();
        #1;
        chk("reset s_req", s_if.req, 0);
        chk("reset grant_id", grant_id, 0);
        chk("reset m0_ack", m0_if.ack, 0);
        chk("reset m1_ack", m1_if.ack, 0);
        chk("reset err", err, 0);
        chk("reset s_addr", s_if.addr, 0);
        chk("reset m0_rdata", m0_if.rdata, 0);

        // table: first tie, zero-bubble handover, ack outside BUSY ignored
        set_m(0, 0, 32'h100, 0, 4'hF, 0);
        set_m(1, 0, 32'h2000, 0, 4'hF, 0);
        for (int i = 0; i < 11; i++) begin
            m0_if.req  = tbl[i].r0;
            m1_if.req  = tbl[i].r1;
            s_if.ack   = tbl[i].sack;
            s_if.rdata = tbl[i].rd;
            #1;
            chk($sformatf("tbl[%0d] s_req", i), s_if.req, tbl[i].e_sreq);
            if (tbl[i].e_sreq) chk($sformatf("tbl[%0d] grant_id", i), grant_id, tbl[i].e_gid);
            chk($sformatf("tbl[%0d] s_addr", i), s_if.addr,
                tbl[i].e_sreq ? (tbl[i].e_gid ? 32'h2000 : 32'h100) : 32'h0);
            chk($sformatf("tbl[%0d] m0_ack", i), m0_if.ack, tbl[i].e_a0);
            chk($sformatf("tbl[%0d] m1_ack", i), m1_if.ack, tbl[i].e_a1);
            chk($sformatf("tbl[%0d] m0_rdata", i), m0_if.rdata, tbl[i].e_a0 ? tbl[i].rd : 32'h0);
            chk($sformatf("tbl[%0d] m1_rdata", i), m1_if.rdata, tbl[i].e_a1 ? tbl[i].rd : 32'h0);
            tick();
        end

        // sustained contention with a zero-wait secondary
        apply_reset();
        set_m(0, 1, 32'h100, 0, 4'hF, 0);
        set_m(1, 1, 32'h2000, 0, 4'hF, 0);
        tick();
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            s_if.ack   = s_if.req;
            s_if.rdata = 32'(k);
            #1;
            chk($sformatf("rr grant[%0d]", k), grant_id, k % 2);
            chk($sformatf("rr s_req[%0d]", k), s_if.req, 1);
            n0 += int'(m0_if.ack);
            n1 += int'(m1_if.ack);
            tick();
        end
        chk("rr m0 ack count", n0, 4);
        chk("rr m1 ack count", n1, 4);

        // single requester, secondary acks two cycles after s_req
        apply_reset();
        set_m(0, 1, 32'h100, 0, 4'hF, 0);
        #1;
        chk("single N s_req", s_if.req, 0);
        tick();
        #1;
        chk("single N+1 s_req", s_if.req, 1);
        chk("single N+1 s_addr", s_if.addr, 32'h100);
        chk("single N+1 grant_id", grant_id, 0);
        chk("single N+1 m0_ack", m0_if.ack, 0);
        tick();
        #1;
        chk("single N+2 m0_ack", m0_if.ack, 0);
        tick();
        s_if.ack   = 1'b1;
        s_if.rdata = 32'hDEADBEEF;
        #1;
        chk("single N+3 m0_ack", m0_if.ack, 1);
        chk("single N+3 m0_rdata", m0_if.rdata, 32'hDEADBEEF);
        chk("single N+3 m1_ack", m1_if.ack, 0);
        chk("single N+3 m1_rdata", m1_if.rdata, 0);
        tick();
        m0_if.req = 1'b0;
        s_if.ack  = 1'b0;
        #1;
        chk("single N+4 s_req", s_if.req, 0);
        chk("single N+4 s_addr", s_if.addr, 0);

        // reset mid-transaction (m0 completed last, so only reset makes m0 win the tie)
        tick();
        set_m(1, 1, 32'h2000, 0, 4'hF, 0);
        tick();
        #1;
        chk("rstmid busy s_req", s_if.req, 1);
        chk("rstmid busy grant_id", grant_id, 1);
        rst = 1'b1;
        m0_if.req = 1'b1;
        tick();
        #1;
        chk("rstmid s_req", s_if.req, 0);
        chk("rstmid m1_ack", m1_if.ack, 0);
        chk("rstmid m0_ack", m0_if.ack, 0);
        rst = 1'b0;
        tick();
        #1;
        chk("rstmid tie s_req", s_if.req, 1);
        chk("rstmid tie grant_id", grant_id, 0);

        // write routing from primary 1
        apply_reset();
        set_m(1, 1, 32'h2000, 1, 4'b0011, 32'h1234ABCD);
        tick();
        #1;
        chk("wr grant_id", grant_id, 1);
        chk("wr s_addr", s_if.addr, 32'h2000);
        chk("wr s_we", s_if.we, 1);
        chk("wr s_be", s_if.be, 4'b0011);
        chk("wr s_wdata", s_if.wdata, 32'h1234ABCD);
        s_if.ack = 1'b1;
        #1;
        chk("wr m1_ack", m1_if.ack, 1);
        chk("wr m0_ack", m0_if.ack, 0);
        tick();
        m1_if.req = 1'b0;
        s_if.ack  = 1'b0;
        #1;
        chk("wr idle s_we", s_if.we, 0);
        chk("wr idle s_wdata", s_if.wdata, 0);

`ifdef SYS_BUS_ARB_TIMEOUT_EN
        // timeout abort, then a real ack landing exactly on the timeout cycle
        apply_reset();
        set_m(0, 1, 32'h300, 0, 4'hF, 0);
        s_if.rdata = 32'hCAFEF00D;
        tick();
        set_m(1, 1, 32'h400, 0, 4'hF, 0);
        for (int k = 1; k <= 64; k++) begin
            #1;
            chk($sformatf("tmo m0_ack@%0d", k), m0_if.ack, k == 64);
            chk($sformatf("tmo err@%0d", k), err, k == 64);
            if (k == 64) chk("tmo m0_rdata", m0_if.rdata, 0);
            tick();
            if (k == 64) m0_if.req = 1'b0;
        end
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) s_if.ack = 1'b1;
            #1;
            if (k == 1) chk("tmo handover grant_id", grant_id, 1);
            chk($sformatf("tmo2 m1_ack@%0d", k), m1_if.ack, k == 64);
            chk($sformatf("tmo2 err@%0d", k), err, 0);
            if (k == 64) chk("tmo2 m1_rdata", m1_if.rdata, 32'hCAFEF00D);
            tick();
        end
        m1_if.req = 1'b0;
        s_if.ack  = 1'b0;
`endif

        // randomized traffic against a transaction-rule reference model
        apply_reset();
        owner = -1;
        last  = 1;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0;
            acked[p] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || acked[p]) begin
                    rq[p]   = ($urandom_range(0, 3) != 0);
                    ad[p]   = $urandom;
                    we_r[p] = 1'($urandom_range(0, 1));
                    be_r[p] = 4'($urandom_range(0, 15));
                    wd[p]   = $urandom;
                end
                set_m(p, rq[p], ad[p], we_r[p], be_r[p], wd[p]);
            end
            sack = ($urandom_range(0, 2) == 0);
            srd  = $urandom;
            s_if.ack   = sack;
            s_if.rdata = srd;
            #1;
            busy_m = (owner >= 0);
            o      = busy_m ? owner : 0;
            ea[0]  = busy_m && (owner == 0) && sack;
            ea[1]  = busy_m && (owner == 1) && sack;
            chk("rnd s_req", s_if.req, busy_m);
            if (busy_m) chk("rnd grant_id", grant_id, o);
            chk("rnd s_addr", s_if.addr, busy_m ? ad[o] : 32'h0);
            chk("rnd s_we", s_if.we, busy_m ? we_r[o] : 1'b0);
            chk("rnd s_be", s_if.be, busy_m ? be_r[o] : 4'h0);
            chk("rnd s_wdata", s_if.wdata, busy_m ? wd[o] : 32'h0);
            chk("rnd m0_ack", m0_if.ack, ea[0]);
            chk("rnd m1_ack", m1_if.ack, ea[1]);
            chk("rnd m0_rdata", m0_if.rdata, ea[0] ? srd : 32'h0);
            chk("rnd m1_rdata", m1_if.rdata, ea[1] ? srd : 32'h0);
            chk("rnd err", err, 0);
            if (owner < 0) begin
                if (rq[0] && rq[1]) owner = 1 - last;
                else if (rq[0]) owner = 0;
                else if (rq[1]) owner = 1;
            end else if (sack) begin
                last  = owner;
                owner = rq[1 - owner] ? 1 - owner : -1;
            end
            acked[0] = ea[0];
            acked[1] = ea[1];
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
